// File: rtl/haar_pkg.sv
// Shared widths, window geometry and types for the Haar integral-image pipeline.
package haar_pkg;
  localparam int DATA_WIDTH_8    = 8;
  localparam int DATA_WIDTH_12   = 12;
  localparam int INTEGRAL_WIDTH  = 3;
  localparam int INTEGRAL_HEIGHT = 3;

  typedef logic [DATA_WIDTH_12-1:0] integral_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;
endpackage

// File: rtl/integral_window_generator_line_buffer.sv
// One image row of integral values, addressed by column.
// Reads are combinational, so a write to the same address only lands after the old value is read.
module line_buffer #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 12,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/integral_window_generator.sv
// Raster integral-image stage: builds mod-4096 integral values on the fly and
// presents the 3x3 integral neighbourhood to the downstream classifier.
module integral_window_generator #(
  parameter int IMAGE_WIDTH     = 16,
  parameter int IMAGE_HEIGHT    = 16,
  parameter int DATA_WIDTH_8    = haar_pkg::DATA_WIDTH_8,
  parameter int DATA_WIDTH_12   = haar_pkg::DATA_WIDTH_12,
  parameter int INTEGRAL_WIDTH  = haar_pkg::INTEGRAL_WIDTH,
  parameter int INTEGRAL_HEIGHT = haar_pkg::INTEGRAL_HEIGHT,
  parameter int HOLD_CYCLES     = 10
) (
  input  logic                     clk_fpga,
  input  logic                     reset_fpga,
  input  logic [DATA_WIDTH_8-1:0]  i_pixel,
  input  logic                     i_pixel_valid,
  input  logic                     i_frame_start,
  output logic                     o_pixel_ready,
  output logic [DATA_WIDTH_12-1:0] o_integral_window [INTEGRAL_WIDTH*INTEGRAL_HEIGHT],
  output logic                     o_window_valid,
  output logic                     o_frame_done
);
  import haar_pkg::*;

  localparam int XW = $clog2(IMAGE_WIDTH);
  localparam int YW = $clog2(IMAGE_HEIGHT);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [XW-1:0] X_LAST    = XW'(IMAGE_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(IMAGE_HEIGHT - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

  state_t          state_q;
  logic [XW-1:0]   x_q;
  logic [YW-1:0]   y_q;
  integral_t       row_sum_q;
  logic [HW-1:0]   hold_q;
  logic            done_pend_q;
  logic            ready_q;
  logic            valid_q;
  logic            fdone_q;
  integral_t       sr_q [INTEGRAL_HEIGHT][INTEGRAL_WIDTH];
  integral_t       sr_d [INTEGRAL_HEIGHT][INTEGRAL_WIDTH];
  integral_t       win_q [INTEGRAL_WIDTH*INTEGRAL_HEIGHT];

  logic            xfer;
  logic            restart;
  logic            accept;
  logic            emit;
  logic            last;
  logic [XW-1:0]   eff_x;
  logic [YW-1:0]   eff_y;
  integral_t       row_sum_d;
  integral_t       lb1_rd;
  integral_t       lb2_rd;
  integral_t       up1;
  integral_t       up2;
  integral_t       integ;

  // A frame-start transfer is taken as (0,0) whether the block was idle or mid-frame.
  assign xfer    = i_pixel_valid && ready_q;
  assign restart = xfer && i_frame_start;
  assign accept  = restart || (xfer && (state_q == ST_STREAM));
  assign eff_x   = restart ? '0 : x_q;
  assign eff_y   = restart ? '0 : y_q;

  assign row_sum_d = ((eff_x == '0) ? '0 : row_sum_q) + integral_t'(i_pixel);
  assign up1       = (eff_y == '0) ? '0 : lb1_rd;
  assign up2       = (eff_y < YW'(2)) ? '0 : lb2_rd;
  assign integ     = row_sum_d + up1;

  assign emit = accept && (eff_x >= XW'(2)) && (eff_y >= YW'(2));
  assign last = accept && (eff_x == X_LAST) && (eff_y == Y_LAST);

  line_buffer #(.DEPTH(IMAGE_WIDTH), .WIDTH(DATA_WIDTH_12)) u_lb_prev1 (
    .clk_i   (clk_fpga),
    .we_i    (accept),
    .addr_i  (eff_x),
    .wdata_i (integ),
    .rdata_o (lb1_rd)
  );

  line_buffer #(.DEPTH(IMAGE_WIDTH), .WIDTH(DATA_WIDTH_12)) u_lb_prev2 (
    .clk_i   (clk_fpga),
    .we_i    (accept),
    .addr_i  (eff_x),
    .wdata_i (up1),
    .rdata_o (lb2_rd)
  );

  // Row 0 carries I(.,y-2), row 1 I(.,y-1), row 2 I(.,y); the newest column enters at the right.
  always_comb begin
    sr_d = sr_q;
    if (accept) begin
      for (int r = 0; r < INTEGRAL_HEIGHT; r++) begin
        for (int c = 0; c < INTEGRAL_WIDTH - 1; c++) begin
          sr_d[r][c] = sr_q[r][c+1];
        end
      end
      sr_d[0][INTEGRAL_WIDTH-1]                 = up2;
      sr_d[1][INTEGRAL_WIDTH-1]                 = up1;
      sr_d[INTEGRAL_HEIGHT-1][INTEGRAL_WIDTH-1] = integ;
    end
  end

  always_ff @(posedge clk_fpga or negedge reset_fpga) begin
    if (!reset_fpga) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      row_sum_q   <= '0;
      hold_q      <= '0;
      done_pend_q <= 1'b0;
      ready_q     <= 1'b0;
      valid_q     <= 1'b0;
      fdone_q     <= 1'b0;
      sr_q        <= '{default: '0};
      win_q       <= '{default: '0};
    end else begin
      valid_q <= 1'b0;
      fdone_q <= 1'b0;
      if (accept) begin
        sr_q      <= sr_d;
        row_sum_q <= row_sum_d;
        fdone_q   <= last;
        if (last) begin
          x_q <= '0;
          y_q <= '0;
        end else if (eff_x == X_LAST) begin
          x_q <= '0;
          y_q <= eff_y + 1'b1;
        end else begin
          x_q <= eff_x + 1'b1;
          y_q <= eff_y;
        end
        if (emit) begin
          valid_q <= 1'b1;
          for (int r = 0; r < INTEGRAL_HEIGHT; r++) begin
            for (int c = 0; c < INTEGRAL_WIDTH; c++) begin
              win_q[r*INTEGRAL_WIDTH+c] <= sr_d[r][c];
            end
          end
        end
      end

      case (state_q)
        ST_IDLE, ST_STREAM: begin
          ready_q <= 1'b1;
          if (emit) begin
            state_q     <= ST_HOLD;
            ready_q     <= 1'b0;
            hold_q      <= HOLD_LOAD;
            done_pend_q <= last;
          end else if (last) begin
            state_q <= ST_IDLE;
          end else if (accept) begin
            state_q <= ST_STREAM;
          end
        end
        ST_HOLD: begin
          if (hold_q == '0) begin
            ready_q     <= 1'b1;
            done_pend_q <= 1'b0;
            state_q     <= done_pend_q ? ST_IDLE : ST_STREAM;
          end else begin
            hold_q <= hold_q - 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_pixel_ready     = ready_q;
  assign o_window_valid    = valid_q;
  assign o_frame_done      = fdone_q;
  assign o_integral_window = win_q;
endmodule

// File: tb/tb_integral_window_generator.sv
// Directed bench for the integral window stage: three instances (4x4, 8x8, 5x6) share one driver.
module tb_integral_window_generator;
  localparam int HOLD = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  pix;
  logic        vld;
  logic        fs;
  int          sel;

  logic        rdy0, rdy1, rdy2, wv0, wv1, wv2, fd0, fd1, fd2;
  logic [11:0] win0 [9];
  logic [11:0] win1 [9];
  logic [11:0] win2 [9];
  logic        cur_rdy, cur_wv, cur_fd;
  logic [11:0] cur_win [9];

  int          checks = 0;
  int          errors = 0;
  int          nwin, nfd;
  bit          expect_hold;
  logic [7:0]  frame_px [64];
  logic [11:0] cap [8][8];
  logic [11:0] first_win [9];
  logic [11:0] last_win [9];
  logic [11:0] exp_first [9] = '{12'd1, 12'd2, 12'd3, 12'd2, 12'd4, 12'd6, 12'd3, 12'd6, 12'd9};
  logic [11:0] exp_last  [9] = '{12'd4, 12'd6, 12'd8, 12'd6, 12'd9, 12'd12, 12'd8, 12'd12, 12'd16};

  always #5 clk = ~clk;

  integral_window_generator #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(4), .HOLD_CYCLES(HOLD)) dut4 (
    .clk_fpga(clk), .reset_fpga(rst_n), .i_pixel(pix), .i_pixel_valid(vld && (sel == 0)),
    .i_frame_start(fs), .o_pixel_ready(rdy0), .o_integral_window(win0),
    .o_window_valid(wv0), .o_frame_done(fd0));

  integral_window_generator #(.IMAGE_WIDTH(8), .IMAGE_HEIGHT(8), .HOLD_CYCLES(HOLD)) dut8 (
    .clk_fpga(clk), .reset_fpga(rst_n), .i_pixel(pix), .i_pixel_valid(vld && (sel == 1)),
    .i_frame_start(fs), .o_pixel_ready(rdy1), .o_integral_window(win1),
    .o_window_valid(wv1), .o_frame_done(fd1));

  integral_window_generator #(.IMAGE_WIDTH(5), .IMAGE_HEIGHT(6), .HOLD_CYCLES(HOLD)) dut56 (
    .clk_fpga(clk), .reset_fpga(rst_n), .i_pixel(pix), .i_pixel_valid(vld && (sel == 2)),
    .i_frame_start(fs), .o_pixel_ready(rdy2), .o_integral_window(win2),
    .o_window_valid(wv2), .o_frame_done(fd2));

  always_comb begin
    cur_rdy = rdy2;
    cur_wv  = wv2;
    cur_fd  = fd2;
    cur_win = win2;
    case (sel)
      0: begin cur_rdy = rdy0; cur_wv = wv0; cur_fd = fd0; cur_win = win0; end
      1: begin cur_rdy = rdy1; cur_wv = wv1; cur_fd = fd1; cur_win = win1; end
      default: ;
    endcase
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference integral by brute-force rectangle summation, truncated to 12 bits.
  function automatic logic [11:0] integ(input int w, input int x, input int y);
    int s;
    s = 0;
    for (int j = 0; j <= y; j++)
      for (int i = 0; i <= x; i++)
        s += int'(frame_px[j*w+i]);
    return s[11:0];
  endfunction

  task automatic send(input logic [7:0] p, input bit f, output int waited);
    waited = 0;
    pix = p;
    vld = 1'b1;
    fs  = f;
    while (!cur_rdy && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 50) check_val("ready_timeout", 32'(waited), 32'd0);
    @(posedge clk); #1;
    vld = 1'b0;
    fs  = 1'b0;
  endtask

  task automatic send_frame(input int w, input int h, input int npix, input bit gaps);
    int waited;
    int x, y;
    bit exp_win;
    for (int k = 0; k < npix; k++) begin
      x = k % w;
      y = k / w;
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send(frame_px[k], k == 0, waited);
      if (expect_hold && !gaps) check_val("hold_len", 32'(waited), 32'(HOLD));
      exp_win = (x >= 2) && (y >= 2);
      check_val($sformatf("wv(%0d,%0d)", x, y), 32'(cur_wv), 32'(exp_win));
      check_val($sformatf("fd(%0d,%0d)", x, y), 32'(cur_fd), 32'(k == w*h-1));
      if (cur_wv) begin
        nwin++;
        cap[y][x] = cur_win[8];
        if (nwin == 1) first_win = cur_win;
        last_win = cur_win;
      end
      if (cur_fd) nfd++;
      if (exp_win) begin
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            check_val($sformatf("win(%0d,%0d)[%0d]", x, y, r*3+c),
                      32'(cur_win[r*3+c]), 32'(integ(w, x-2+c, y-2+r)));
      end
      expect_hold = exp_win;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int waited;
    logic [11:0] rect;
    rst_n = 1'b0; vld = 1'b0; fs = 1'b0; pix = '0; sel = 0; expect_hold = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ready", 32'(cur_rdy), 32'd0);
    check_val("rst_wv", 32'(cur_wv), 32'd0);
    check_val("rst_fd", 32'(cur_fd), 32'd0);
    check_val("rst_win4", 32'(cur_win[4]), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    #1 check_val("ready_before_edge", 32'(cur_rdy), 32'd0);
    @(posedge clk); #1;
    check_val("ready_after_release", 32'(cur_rdy), 32'd1);

    // 4x4 all ones, back to back with valid held through each hold
    for (int k = 0; k < 16; k++) frame_px[k] = 8'd1;
    nwin = 0; nfd = 0;
    send_frame(4, 4, 16, 1'b0);
    check_val("ones_nwin", 32'(nwin), 32'd4);
    check_val("ones_nfd", 32'(nfd), 32'd1);
    for (int i = 0; i < 9; i++) begin
      check_val($sformatf("first_win[%0d]", i), 32'(first_win[i]), 32'(exp_first[i]));
      check_val($sformatf("last_win[%0d]", i), 32'(last_win[i]), 32'(exp_last[i]));
    end

    // Restart at (1,3): prefix of one frame, then a fresh frame begins on that pixel
    for (int k = 0; k < 16; k++) frame_px[k] = 8'($urandom_range(0, 255));
    nwin = 0; nfd = 0;
    send_frame(4, 4, 13, 1'b0);
    check_val("prefix_nfd", 32'(nfd), 32'd0);
    for (int k = 0; k < 16; k++) frame_px[k] = 8'($urandom_range(0, 255));
    nwin = 0; nfd = 0;
    send_frame(4, 4, 16, 1'b0);
    check_val("restart_nwin", 32'(nwin), 32'd4);
    check_val("restart_nfd", 32'(nfd), 32'd1);

    // Reset while holding after the (2,2) window
    for (int k = 0; k < 16; k++) frame_px[k] = 8'd2;
    nwin = 0; nfd = 0;
    send_frame(4, 4, 11, 1'b0);
    check_val("hold_ready_low", 32'(cur_rdy), 32'd0);
    check_val("pre_reset_win8", 32'(cur_win[8]), 32'd18);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_val("midhold_rst_ready", 32'(cur_rdy), 32'd0);
    check_val("midhold_rst_win8", 32'(cur_win[8]), 32'd0);
    check_val("midhold_rst_win0", 32'(cur_win[0]), 32'd0);
    check_val("midhold_rst_fd", 32'(cur_fd), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1 check_val("rerelease_before_edge", 32'(cur_rdy), 32'd0);
    @(posedge clk); #1;
    check_val("rerelease_ready", 32'(cur_rdy), 32'd1);
    send(8'd9, 1'b0, waited);
    check_val("discard_wv", 32'(cur_wv), 32'd0);
    check_val("discard_ready", 32'(cur_rdy), 32'd1);
    expect_hold = 1'b0;
    for (int k = 0; k < 16; k++) frame_px[k] = 8'd3;
    nwin = 0; nfd = 0;
    send_frame(4, 4, 16, 1'b0);
    check_val("after_reset_nwin", 32'(nwin), 32'd4);

    // 8x8 saturated pixels: integral wraps modulo 4096
    sel = 1; expect_hold = 1'b0;
    for (int k = 0; k < 64; k++) frame_px[k] = 8'd255;
    nwin = 0; nfd = 0;
    send_frame(8, 8, 64, 1'b0);
    check_val("sat_nwin", 32'(nwin), 32'd36);
    check_val("sat_I77", 32'(cur_win[8]), 32'd4032);
    rect = cap[7][7] - cap[7][4] - cap[4][7] + cap[4][4];
    check_val("sat_rect3x3", 32'(rect), 32'd2295);

    // 5x6 random pixels with random valid gaps, two frames
    sel = 2; expect_hold = 1'b0;
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 30; k++) frame_px[k] = 8'($urandom_range(0, 255));
      nwin = 0; nfd = 0;
      send_frame(5, 6, 30, 1'b1);
      check_val("rand_nwin", 32'(nwin), 32'd12);
      check_val("rand_nfd", 32'(nfd), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
